pixel_receiver: RTL

PIXEL_RECEIVER -- requirements
Module: pixel_receiver

---
 rtl/pixel_receiver.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_receiver.sv
// -----------------------------------------------------------------------------
// pixel_receiver
//
// Decodes a WS2812B-style single-wire pixel stream into 24-bit pixels. Each bit
// is a high pulse whose width (in clk cycles) selects 0 or 1; a long low period
// is a reset gap that frames the stream. Decoded pixels are offered on a
// valid/ready interface together with a frame_start qualifier.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   din          asynchronous serial data line
//   color[23:0]  decoded pixel, first received bit in color[23]
//   valid        color holds an undelivered pixel
//   ready        consumer accepts color when valid && ready
//   frame_start  color is the first pixel after a reset gap
//   pulse_err    one-cycle pulse: illegal high width seen
//   frame_err    one-cycle pulse: reset gap arrived with 1..23 bits pending
//   overrun      one-cycle pulse: pixel completed while valid && !ready
// -----------------------------------------------------------------------------
module pixel_receiver #(
    parameter int TCK_ZR_MIN = 3,
    parameter int TCK_THRESH = 10,
    parameter int TCK_ON_MAX = 17,
    parameter int TCK_RESET  = 800,
    parameter int TCK_BITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] color,
    output logic        valid,
    input  logic        ready,
    output logic        frame_start,
    output logic        pulse_err,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [TCK_BITS-1:0] CNT_MAX   = '1;
    localparam logic [TCK_BITS-1:0] CNT_ONE   = TCK_BITS'(1);
    localparam logic [TCK_BITS-1:0] ZR_MIN    = TCK_BITS'(TCK_ZR_MIN);
    localparam logic [TCK_BITS-1:0] THRESH    = TCK_BITS'(TCK_THRESH);
    localparam logic [TCK_BITS-1:0] ON_MAX    = TCK_BITS'(TCK_ON_MAX);
    localparam logic [TCK_BITS-1:0] RESET_LEN = TCK_BITS'(TCK_RESET);
    localparam logic [4:0]          LAST_BIT  = 5'd23;

    logic                din_meta;
    logic                din_s;
    logic [1:0]          state;
    logic [TCK_BITS-1:0] cnt;        // high width in HIGH, low width elsewhere
    logic [4:0]          bit_cnt;
    logic [22:0]         shreg;      // bits received so far in this pixel
    logic                frame_flag; // a reset gap preceded the pixel in progress

    logic [TCK_BITS-1:0] cnt_inc;
    logic                width_bad;
    logic                rx_bit;
    logic                gap_hit;
    logic                can_load;
    logic [23:0]         pixel_next;

    always_comb begin
        // Saturating increment: a gap longer than TCK_RESET behaves like exactly TCK_RESET.
        cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        width_bad  = (cnt < ZR_MIN) || (cnt > ON_MAX);
        rx_bit     = (cnt >= THRESH);
        gap_hit    = (cnt_inc >= RESET_LEN);
        // A held pixel being accepted this very cycle frees the output register.
        can_load   = !valid || ready;
        pixel_next = {shreg, rx_bit};
    end

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_meta    <= 1'b0;
            din_s       <= 1'b0;
            state       <= ST_SYNC;
            cnt         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            frame_flag  <= 1'b0;
            color       <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            pulse_err   <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;

            // NOTE: the event outputs default low here and are overridden
            // below, which makes them single-cycle pulses with no extra logic.
            pulse_err <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Handshake completes; a pixel loaded below in the same cycle wins.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                ST_SYNC: begin
                    // Wait for a full reset gap before trusting any pulse.
                    if (din_s) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (gap_hit) begin
                            state      <= ST_IDLE;
                            frame_flag <= 1'b1;
                        end
                    end
                end

                ST_IDLE: begin
                    if (din_s) begin
                        state <= ST_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= cnt_inc;
                        if (gap_hit) begin
                            frame_flag <= 1'b1;
                        end
                    end
                end

                ST_HIGH: begin
                    if (din_s) begin
                        cnt <= cnt_inc;
                    end else if (width_bad) begin
                        // Lost bit alignment: drop the partial pixel and resync.
                        // This cycle is already low, so it counts toward the gap.
                        pulse_err  <= 1'b1;
                        bit_cnt    <= '0;
                        shreg      <= '0;
                        frame_flag <= 1'b0;
                        cnt        <= CNT_ONE;
                        state      <= ST_SYNC;
                    end else begin
                        shreg <= pixel_next[22:0];
                        cnt   <= CNT_ONE;
                        state <= ST_LOW;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            frame_flag <= 1'b0;
                            if (can_load) begin
                                color       <= pixel_next;
                                valid       <= 1'b1;
                                frame_start <= frame_flag;
                            end else begin
                                // Held pixel is kept; the new one is dropped.
                                overrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                ST_LOW: begin
                    if (din_s) begin
                        state <= ST_HIGH;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= cnt_inc;
                        if (gap_hit) begin
                            state      <= ST_IDLE;
                            frame_flag <= 1'b1;
                            if (bit_cnt != 5'd0) begin
                                frame_err <= 1'b1;
                            end
                            bit_cnt <= '0;
                            shreg   <= '0;
                        end
                    end
                end

                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule
